// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel frame receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 3;

    // Bit counter must hold the value WIDTH itself so it can saturate without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit deserialising shift register; `word` shows the contents including
// the bit shifted in this cycle, so the top can capture a completed frame on the same edge.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;

    // LSB-first enters at the top and moves down, so the first bit ends in bit 0.
    always_comb begin
        base = clear ? '0 : q;
        if (LSB_FIRST) shifted = {serial_in, base[WIDTH-1:1]};
        else           shifted = {base[WIDTH-2:0], serial_in};
        word = shift_en ? shifted : q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset)        q <= '0;
        else if (shift_en) q <= shifted;
    end

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial frame receiver with registered valid/ready output buffer and sticky error flags.
// Optional parity bit after each frame when SIPO_PARITY_CHECK_EN is defined.
module sipo_frame_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_abort,
    output logic             parity_err
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH);

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             shift_en, clear, complete, abort;
    logic [WIDTH-1:0] word;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .clear     (clear),
        .serial_in (serial_in),
        .word      (word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_en   = 1'b0;
        clear      = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        if (frame_start) begin
            // A start in any non-idle cycle, including the completing one, restarts reception.
            abort      = (state != IDLE);
            state_next = SHIFT;
            cnt_next   = CW'(1);
            shift_en   = 1'b1;
            clear      = 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    shift_en = 1'b1;
                    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_CHECK_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
                        complete   = 1'b1;
`endif
                    end
                end
`ifdef SIPO_PARITY_CHECK_EN
                PARITY: begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // A completed word loads only if the buffer is empty or draining on this same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out    <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            if (abort) frame_abort <= 1'b1;
            if (complete) begin
                if (!out_valid || out_ready) begin
                    data_out  <= word;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    // In PARITY the core is not shifting, so word holds the full data and serial_in is the parity bit.
    always_ff @(posedge clk) begin
        if (!reset)                            parity_err <= 1'b0;
        else if (complete && (^word ^ serial_in)) parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Scoreboard bench for sipo_frame_receiver (default build, WIDTH=3, LSB first).
module tb_sipo_frame_receiver;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         serial_in = 1'b0;
    logic         frame_start = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         out_valid, busy, overrun, frame_abort, parity_err;

    always #5 clk = ~clk;

    sipo_frame_receiver #(
        .WIDTH     (W),
        .LSB_FIRST (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .frame_start (frame_start),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun),
        .frame_abort (frame_abort),
        .parity_err  (parity_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits collected per frame, word built by weighting bit i with 2**i.
    int           m_nbits = 0;
    logic [W-1:0] m_acc = '0;
    bit           m_valid = 1'b0;
    bit           m_overrun = 1'b0;
    bit           m_abort = 1'b0;
    logic [W-1:0] exp_q[$];
    bit           mon_en = 1'b0;
    logic [W-1:0] mon_exp;

    task automatic model_step(input bit fs, input bit si, input bit rdy);
        bit consume;
        bit done;
        consume = m_valid && rdy;
        done    = 1'b0;
        if (fs) begin
            if (m_nbits > 0) m_abort = 1'b1;
            m_nbits = 1;
            m_acc   = W'(si);
        end else if (m_nbits > 0) begin
            m_acc   = m_acc + (si ? W'(1 << m_nbits) : W'(0));
            m_nbits = m_nbits + 1;
            if (m_nbits == W) begin
                done    = 1'b1;
                m_nbits = 0;
            end
        end
        if (done) begin
            if (!m_valid || consume) begin
                m_valid = 1'b1;
                exp_q.push_back(m_acc);
            end else begin
                m_overrun = 1'b1;
            end
        end else if (consume) begin
            m_valid = 1'b0;
        end
    endtask

    // Inputs change 1 time unit after each rising edge; the model steps on the edge.
    task automatic cycle(input bit fs, input bit si, input bit rdy);
        frame_start = fs;
        serial_in   = si;
        out_ready   = rdy;
        @(posedge clk);
        model_step(fs, si, rdy);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        m_nbits   = 0;
        m_acc     = '0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_abort   = 1'b0;
        exp_q.delete();
        #1;
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset flags", {28'd0, out_valid, busy, overrun, frame_abort}, 32'd0);
        reset = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input int rdy_pct);
        for (int i = 0; i < W; i++)
            cycle(i == 0, w[i], $urandom_range(99) < rdy_pct);
    endtask

    // Monitor: mid-cycle, compare control outputs with the model and pop on each handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_nbits > 0));
            check("overrun", 32'(overrun), 32'(m_overrun));
            check("frame_abort", 32'(frame_abort), 32'(m_abort));
            check("parity_err", 32'(parity_err), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word unexpected actual=%0h expected=none at %0t", data_out, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("word", 32'(data_out), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #1;
        do_reset();
        mon_en = 1'b1;

        // Basic frame: bits 0,1,1 -> 3'b110 visible the cycle after the last bit.
        send_frame(3'b110, 100);
        check("basic valid", 32'(out_valid), 32'd1);
        check("basic data", 32'(data_out), 32'b110);
        cycle(0, 0, 1);
        check("basic drop", 32'(out_valid), 32'd0);

        // Back-to-back frames with no gap.
        send_frame(3'b101, 100);
        send_frame(3'b010, 100);
        check("b2b second", 32'(data_out), 32'b010);
        cycle(0, 1, 1);
        check("b2b no overrun", 32'(overrun), 32'd0);

        // Overrun: 111 held while 001 completes and is dropped.
        send_frame(3'b111, 0);
        send_frame(3'b001, 0);
        cycle(0, 1, 0);
        check("overrun flag", 32'(overrun), 32'd1);
        check("overrun held", 32'(data_out), 32'b111);
        cycle(0, 0, 1);
        cycle(0, 0, 1);

        // Abort: restart one cycle in, then bits 1,0,0.
        cycle(1, 0, 1);
        send_frame(3'b001, 100);
        check("abort flag", 32'(frame_abort), 32'd1);
        check("abort data", 32'(data_out), 32'b001);
        cycle(0, 0, 1);

        // Start on the completing cycle aborts that frame.
        cycle(1, 1, 1);
        cycle(0, 1, 1);
        send_frame(3'b100, 100);
        cycle(0, 0, 1);

        // Reset mid-frame, then a clean frame.
        cycle(1, 1, 1);
        do_reset();
        send_frame(3'b011, 100);
        check("post-reset data", 32'(data_out), 32'b011);
        cycle(0, 0, 1);

        // Randomised traffic: idle garbage, frames with occasional restarts, random backpressure.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(99) < 4) begin
                do_reset();
            end else begin
                for (int g = $urandom_range(2); g > 0; g--)
                    cycle(0, 1'($urandom), $urandom_range(99) < 60);
                for (int i = 0; i < W; i++)
                    cycle((i == 0) || ($urandom_range(99) < 5), 1'($urandom),
                          $urandom_range(99) < 60);
            end
        end

        // Drain: leftover frame finishes and the buffer empties.
        for (int i = 0; i < W + 3; i++) cycle(0, 0, 1);
        check("drain queue", 32'(exp_q.size()), 32'd0);
        check("drain valid", 32'(out_valid), 32'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
